// File: rtl/bcd_pkg.sv
// Shared widths, FSM state encoding and the double-dabble nibble correction
// for the BCD converter arbiter.
package bcd_pkg;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned BIN_W   = 14;
    localparam int unsigned BCD_W   = 16;
    localparam int unsigned MAX_VAL = 9999;
    localparam int unsigned N_ITER  = 14;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DELIVER
    } state_e;

    // Pre-shift correction: a digit of 5 or more would overflow 9 once doubled.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/bcd_convert_arbiter_core.sv
// Sequential shift-and-add-3 converter: one correction+shift per cycle,
// N_ITER cycles per operand, single-cycle done pulse.
module bcd_shift_core
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [13:0]      bin,
    output logic             done,
    output logic [15:0]      bcd
);

    logic                  active_q, active_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIN_W-1:0]      bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [BCD_W-1:0]      corr_c;
    logic [BCD_W+BIN_W-1:0] shifted_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
        end else begin
            active_q <= active_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
        end
    end

    always_comb begin
        active_d  = active_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        corr_c    = {add3(bcd_q[15:12]), add3(bcd_q[11:8]),
                     add3(bcd_q[7:4]),   add3(bcd_q[3:0])};
        shifted_c = {corr_c, bin_q} << 1;

        if (!active_q) begin
            // start while active is ignored by construction
            if (start) begin
                active_d = 1'b1;
                cnt_d    = '0;
                bin_d    = bin;
                bcd_d    = '0;
            end
        end else begin
            bcd_d = shifted_c[BCD_W+BIN_W-1:BIN_W];
            bin_d = shifted_c[BIN_W-1:0];
            if (cnt_q == CNT_W'(N_ITER - 1)) begin
                cnt_d    = '0;
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            end
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter sharing one sequential binary-to-BCD converter among
// four requesters; clamps operands above MAX_VAL and flags them with ovf.
module bcd_convert_arbiter
    import bcd_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*BIN_W-1:0]   bin_in,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic [N_REQ-1:0]         valid,
    output logic [BCD_W-1:0]         bcd_out,
    output logic                     ovf
);

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    winner_q, winner_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    valid_q, valid_d;
    logic [BIN_W-1:0]    opnd_q, opnd_d;
    logic                ovf_next_q, ovf_next_d;
    logic [BCD_W-1:0]    bcd_out_q, bcd_out_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;

    logic                found_c;
    logic [PTR_W-1:0]    win_c;
    logic [PTR_W-1:0]    idx_c;
    logic [BIN_W-1:0]    slice_c;
    logic                start_c;
    logic                core_done;
    logic [BCD_W-1:0]    core_bcd;

    bcd_shift_core u_core (
        .clk   (clk),
        .rst   (rst),
        .start (start_c),
        .bin   (opnd_q),
        .done  (core_done),
        .bcd   (core_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            winner_q   <= '0;
            grant_q    <= '0;
            valid_q    <= '0;
            opnd_q     <= '0;
            ovf_next_q <= 1'b0;
            bcd_out_q  <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            opnd_q     <= opnd_d;
            ovf_next_q <= ovf_next_d;
            bcd_out_q  <= bcd_out_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
        end
    end

    // First requesting index at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found_c = 1'b0;
        win_c   = ptr_q;
        idx_c   = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            idx_c = PTR_W'(ptr_q + PTR_W'(k));
            if (!found_c && req[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
        slice_c = bin_in[win_c*BIN_W +: BIN_W];
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        winner_d   = winner_q;
        grant_d    = grant_q;
        valid_d    = '0;
        opnd_d     = opnd_q;
        ovf_next_d = ovf_next_q;
        bcd_out_d  = bcd_out_q;
        ovf_d      = ovf_q;
        start_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    grant_d    = N_REQ'(1) << win_c;
                    winner_d   = win_c;
                    ovf_next_d = (slice_c > BIN_W'(MAX_VAL));
                    opnd_d     = ovf_next_d ? BIN_W'(MAX_VAL) : slice_c;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                start_c = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    valid_d   = grant_q;
                    bcd_out_d = core_bcd;
                    ovf_d     = ovf_next_q;
                    ptr_d     = PTR_W'(winner_q + PTR_W'(1));
                    state_d   = S_DELIVER;
                end
            end
            S_DELIVER: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign bcd_out = bcd_out_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Self-checking bench for bcd_convert_arbiter: decimal-arithmetic reference
// and a scan-based round-robin model drive the expectations.
module tb_bcd_convert_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [55:0] bin_in;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  valid;
    logic [15:0] bcd_out;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;

    bcd_convert_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .bin_in  (bin_in),
        .grant   (grant),
        .busy    (busy),
        .valid   (valid),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int unsigned v);
        int unsigned c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic int ref_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int unsigned v);
        bin_in[i*14 +: 14] = 14'(v);
    endtask

    // Steps until valid is nonzero or the limit expires; n counts steps taken.
    task automatic wait_valid(input int limit, output int n, output bit timeout);
        n = 0;
        timeout = 1'b1;
        while (n < limit) begin
            step();
            n++;
            if (valid !== 4'b0) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
        mptr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (grant !== 4'b0)   begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
        total++; if (valid !== 4'b0)   begin bad++; $display("FAIL reset_valid got=%b want=0000", valid); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (bcd_out !== 16'h0) begin bad++; $display("FAIL reset_bcd got=%h want=0000", bcd_out); end
        total++; if (ovf !== 1'b0)     begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    endtask

    task automatic test_single();
        int n;
        bit grant_ok;
        set_op(0, 1234);
        req = 4'b0001;
        n = 0;
        grant_ok = 1'b1;
        while (n < 40) begin
            step();
            n++;
            if (grant !== 4'b0001) grant_ok = 1'b0;
            if (valid !== 4'b0) break;
        end
        req = '0;
        total++; if (n != 17)            begin bad++; $display("FAIL single_latency got=%0d want=17", n); end
        total++; if (!grant_ok)          begin bad++; $display("FAIL single_grant_stable got=unstable want=0001"); end
        total++; if (valid !== 4'b0001)  begin bad++; $display("FAIL single_valid got=%b want=0001", valid); end
        total++; if (bcd_out !== 16'h1234) begin bad++; $display("FAIL single_bcd got=%h want=1234", bcd_out); end
        total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL single_ovf got=%b want=0", ovf); end
        step();
        total++; if (valid !== 4'b0)     begin bad++; $display("FAIL single_valid_pulse got=%b want=0000", valid); end
        total++; if (bcd_out !== 16'h1234) begin bad++; $display("FAIL single_bcd_hold got=%h want=1234", bcd_out); end
        total++; if (busy !== 1'b0 || grant !== 4'b0) begin bad++; $display("FAIL single_idle got=busy%b/grant%b want=0/0000", busy, grant); end
        mptr = 1;
    endtask

    task automatic test_boundaries();
        int unsigned vals[8];
        int n, who;
        bit to;
        vals[0] = 0; vals[1] = 9999; vals[2] = 10000; vals[3] = 16383;
        for (int j = 4; j < 8; j++) vals[j] = $urandom_range(0, 16383);
        for (int j = 0; j < 8; j++) begin
            who = $urandom_range(0, 3);
            bin_in = 56'($urandom()) ^ (56'($urandom()) << 28);
            set_op(who, vals[j]);
            req = 4'b0001 << who;
            wait_valid(40, n, to);
            req = '0;
            total++; if (to || n != 17) begin bad++; $display("FAIL bound_latency v=%0d got=%0d want=17", vals[j], n); end
            total++; if (valid !== (4'b0001 << who)) begin bad++; $display("FAIL bound_valid v=%0d got=%b want=%b", vals[j], valid, 4'b0001 << who); end
            total++; if (bcd_out !== ref_bcd(vals[j])) begin bad++; $display("FAIL bound_bcd v=%0d got=%h want=%h", vals[j], bcd_out, ref_bcd(vals[j])); end
            total++; if (ovf !== (vals[j] > 9999)) begin bad++; $display("FAIL bound_ovf v=%0d got=%b want=%b", vals[j], ovf, vals[j] > 9999); end
            mptr = (who + 1) % 4;
            step();
        end
    endtask

    task automatic test_contention();
        int unsigned v[4];
        int n, w;
        bit to;
        do_reset();
        v[0] = 1; v[1] = 22; v[2] = 333; v[3] = 4444;
        for (int i = 0; i < 4; i++) set_op(i, v[i]);
        req = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            w = ref_pick(req, mptr);
            wait_valid(60, n, to);
            total++; if (to || n != (s == 0 ? 17 : 18)) begin bad++; $display("FAIL cont_interval s=%0d got=%0d want=%0d", s, n, s == 0 ? 17 : 18); end
            total++; if (valid !== (4'b0001 << w)) begin bad++; $display("FAIL cont_order s=%0d got=%b want=%b", s, valid, 4'b0001 << w); end
            total++; if (bcd_out !== ref_bcd(v[w])) begin bad++; $display("FAIL cont_bcd s=%0d got=%h want=%h", s, bcd_out, ref_bcd(v[w])); end
            req[w] = 1'b0;
            mptr = (w + 1) % 4;
        end
        step();
    endtask

    task automatic test_fairness();
        int unsigned v0, v2;
        int n, w;
        bit to;
        v0 = $urandom_range(0, 9999);
        v2 = $urandom_range(0, 16383);
        set_op(0, v0);
        set_op(2, v2);
        req = 4'b0101;
        for (int s = 0; s < 4; s++) begin
            w = ref_pick(req, mptr);
            wait_valid(60, n, to);
            total++; if (to || valid !== (4'b0001 << w)) begin bad++; $display("FAIL fair_grant s=%0d got=%b want=%b", s, valid, 4'b0001 << w); end
            total++; if (bcd_out !== ref_bcd(w == 0 ? v0 : v2)) begin bad++; $display("FAIL fair_bcd s=%0d got=%h want=%h", s, bcd_out, ref_bcd(w == 0 ? v0 : v2)); end
            mptr = (w + 1) % 4;
        end
        req = '0;
        step();
    endtask

    task automatic test_withdraw();
        int unsigned v;
        int n;
        bit to;
        v = $urandom_range(0, 16383);
        set_op(1, v);
        req = 4'b0010;
        for (int c = 0; c < 8; c++) step();
        req = '0;
        set_op(1, v ^ 14'h2AAA);
        wait_valid(40, n, to);
        total++; if (to || n != 9) begin bad++; $display("FAIL wd_latency got=%0d want=9", n); end
        total++; if (valid !== 4'b0010) begin bad++; $display("FAIL wd_valid got=%b want=0010", valid); end
        total++; if (bcd_out !== ref_bcd(v) || ovf !== (v > 9999)) begin bad++; $display("FAIL wd_result got=%h/%b want=%h/%b", bcd_out, ovf, ref_bcd(v), v > 9999); end
        mptr = 2;
        step();
        total++; if (busy !== 1'b0 || grant !== 4'b0) begin bad++; $display("FAIL wd_idle got=busy%b/grant%b want=0/0000", busy, grant); end
    endtask

    task automatic test_reset_mid();
        int unsigned v2, v3;
        int n, w;
        bit to, seen;
        v2 = $urandom_range(0, 9999);
        v3 = $urandom_range(0, 16383);
        set_op(2, v2);
        set_op(3, v3);
        // serve requester 2 so the pointer sits on 3 before the abort
        req = 4'b0100;
        wait_valid(40, n, to);
        req = '0;
        mptr = 3;
        step();
        req = 4'b1000;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (valid !== 4'b0) seen = 1'b1;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        mptr = 0;
        total++; if (seen) begin bad++; $display("FAIL rstmid_novalid got=pulse want=none"); end
        total++; if (grant !== 4'b0 || busy !== 1'b0 || valid !== 4'b0) begin bad++; $display("FAIL rstmid_ctrl got=%b/%b/%b want=0000/0/0000", grant, busy, valid); end
        total++; if (bcd_out !== 16'h0 || ovf !== 1'b0) begin bad++; $display("FAIL rstmid_data got=%h/%b want=0000/0", bcd_out, ovf); end
        req = 4'b1100;
        for (int s = 0; s < 2; s++) begin
            w = ref_pick(req, mptr);
            wait_valid(60, n, to);
            total++; if (to || valid !== (4'b0001 << w)) begin bad++; $display("FAIL rstmid_order s=%0d got=%b want=%b", s, valid, 4'b0001 << w); end
            total++; if (bcd_out !== ref_bcd(w == 2 ? v2 : v3) || ovf !== ((w == 2 ? v2 : v3) > 9999)) begin bad++; $display("FAIL rstmid_bcd s=%0d got=%h want=%h", s, bcd_out, ref_bcd(w == 2 ? v2 : v3)); end
            req[w] = 1'b0;
            mptr = (w + 1) % 4;
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        bin_in = '0;
        test_reset();
        test_single();
        test_boundaries();
        test_contention();
        test_fairness();
        test_withdraw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
